// File: rtl/meas_tx_pkg.sv
// Shared types and constants for the measurement TX sequencer.
// Optional frame header: define MEAS_TX_HEADER_EN.
package meas_tx_pkg;

`ifdef MEAS_TX_HEADER_EN
  localparam bit HEADER_EN = 1'b1;
`else
  localparam bit HEADER_EN = 1'b0;
`endif

  localparam logic [7:0] CMD_START   = 8'h00;
  localparam logic [7:0] CMD_STOP    = 8'h01;
  localparam logic [7:0] CMD_SINGLE  = 8'h02;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_SUM,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CONT   = 2'd1,
    MODE_SINGLE = 2'd2
  } mode_e;

  function automatic int frame_len(input int n);
    return n + (HEADER_EN ? 1 : 0);
  endfunction

  function automatic int sel_w(input int n);
    int w;
    w = $clog2(frame_len(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/meas_tx_sequencer_if.sv
// Command/accumulator/UART-TX bundle of the sequencer.
// slave = sequencer side, master = environment side.
interface meas_tx_sequencer_if #(
  parameter int SEL_W = 2
);
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             sum_ready;
  logic             tx_busy;
  logic             sum_en;
  logic             tx_send;
  logic [SEL_W-1:0] send_sel;
  logic [1:0]       mode;
  logic             err_cmd;

  modport slave (
    input  rx_ready, rx_data, sum_ready, tx_busy,
    output sum_en, tx_send, send_sel, mode, err_cmd
  );

  modport master (
    output rx_ready, rx_data, sum_ready, tx_busy,
    input  sum_en, tx_send, send_sel, mode, err_cmd
  );
endinterface

// File: rtl/meas_tx_sequencer_timer.sv
// State timer: clears on request, else counts up and saturates.
// Compares against the ack timeout and the inter-byte gap.
module seq_timer #(
  parameter int TIMER_W     = 16,
  parameter int GAP_CYCLES  = 100,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic ack_to,
  output logic gap_done
);
  logic [TIMER_W-1:0] cnt_q;

  // count time spent in the current state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ack_to   = cnt_q >= TIMER_W'(ACK_TIMEOUT);
  assign gap_done = cnt_q >= TIMER_W'(GAP_CYCLES - 1);
endmodule

// File: rtl/meas_tx_sequencer.sv
// UART command decoder and result-frame TX sequencer.
// Frame header enabled by MEAS_TX_HEADER_EN (see pkg).
module meas_tx_sequencer
  import meas_tx_pkg::*;
#(
  parameter int NUM_BYTES   = 3,
  parameter int GAP_CYCLES  = 100,
  parameter int ACK_TIMEOUT = 64,
  parameter int TIMER_W     = 16
) (
  input logic                clk,
  input logic                reset_n,
  meas_tx_sequencer_if.slave bus
);
  localparam int SEL_W = sel_w(NUM_BYTES);
  localparam logic [SEL_W-1:0] LAST_IDX =
    SEL_W'(NUM_BYTES - 1);
  localparam logic [SEL_W-1:0] FIRST_IDX =
    HEADER_EN ? SEL_W'(NUM_BYTES) : SEL_W'(0);

  state_e           state_q, state_n;
  mode_e            mode_q, mode_n;
  logic [SEL_W-1:0] idx_q, idx_n;
  logic [SEL_W-1:0] idx_inc;
  logic             pend_q, pend_n;
  logic [7:0]       cmd_q;
  logic             in_frame;
  logic             known;
  logic             ack_to;
  logic             gap_done;

  seq_timer #(
    .TIMER_W    (TIMER_W),
    .GAP_CYCLES (GAP_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_n != state_q),
    .ack_to  (ack_to),
    .gap_done(gap_done)
  );

  assign in_frame = (state_q == S_SEND)
                 || (state_q == S_WAIT_ACK)
                 || (state_q == S_WAIT_DONE)
                 || (state_q == S_GAP);

  assign known = (cmd_q == CMD_START)
              || (cmd_q == CMD_STOP)
              || (cmd_q == CMD_SINGLE);

  // header code wraps to the first data byte
  assign idx_inc = (HEADER_EN && idx_q == FIRST_IDX)
                 ? '0 : idx_q + 1'b1;

  // state, mode, index, pending flag, command latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_OFF;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      idx_q   <= idx_n;
      pend_q  <= pend_n;
      if (bus.rx_ready) cmd_q <= bus.rx_data;
    end
  end

  // next-state logic; frames always run to completion
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    idx_n   = idx_q;
    pend_n  = pend_q;
    if (bus.rx_ready && in_frame) pend_n = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        pend_n = 1'b0;
        if (!bus.rx_ready) begin
          unique case (1'b1)
            cmd_q == CMD_START: begin
              mode_n  = MODE_CONT;
              state_n = S_WAIT_SUM;
            end
            cmd_q == CMD_SINGLE: begin
              mode_n  = MODE_SINGLE;
              state_n = S_WAIT_SUM;
            end
            cmd_q == CMD_STOP: begin
              mode_n  = MODE_OFF;
              state_n = S_IDLE;
            end
            default: begin
              state_n = (mode_q == MODE_OFF)
                      ? S_IDLE : S_WAIT_SUM;
            end
          endcase
        end
      end
      S_WAIT_SUM: begin
        if (bus.rx_ready) begin
          state_n = S_DECODE;
        end else if (bus.sum_ready) begin
          state_n = S_SEND;
          idx_n   = FIRST_IDX;
        end
      end
      S_SEND: begin
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) state_n = S_WAIT_DONE;
        else if (ack_to) state_n = S_GAP;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_done) begin
          if (idx_q != LAST_IDX) begin
            idx_n   = idx_inc;
            state_n = S_SEND;
          end else begin
            idx_n = '0;
            if (mode_q == MODE_SINGLE) mode_n = MODE_OFF;
            if (pend_q || bus.rx_ready) begin
              pend_n  = 1'b0;
              state_n = S_DECODE;
            end else if (mode_q == MODE_CONT) begin
              state_n = S_WAIT_SUM;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.sum_en   = (state_q == S_WAIT_SUM);
  assign bus.tx_send  = (state_q == S_SEND);
  assign bus.send_sel = idx_q;
  assign bus.mode     = mode_q;
  assign bus.err_cmd  = (state_q == S_DECODE) && !known;
endmodule

// File: tb/tb_meas_tx_sequencer.sv
// Directed bench for meas_tx_sequencer with a send_sel
// scoreboard and a busy-for-10-cycles UART model.
module tb_meas_tx_sequencer;
  localparam int NB  = 3;
  localparam int GAP = 4;
  localparam int ACK = 8;
`ifdef MEAS_TX_HEADER_EN
  localparam int FL   = 4;
  localparam int HOFF = 1;
`else
  localparam int FL   = 3;
  localparam int HOFF = 0;
`endif
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic uart_en;
  int   cyc = 0;
  int   n_tx = 0;
  int   last_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tgt = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] obs_q[$];

  meas_tx_sequencer_if #(.SEL_W(SW)) bus();

  meas_tx_sequencer #(
    .NUM_BYTES  (NB),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ACK),
    .TIMER_W    (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_send === 1'b1) begin
        obs_q.push_back(bus.send_sel);
        n_tx     = n_tx + 1;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_send === 1'b1 && uart_en) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic pulse_sum();
    bus.sum_ready = 1'b1;
    tick(1);
    bus.sum_ready = 1'b0;
  endtask

  task automatic push_frame();
`ifdef MEAS_TX_HEADER_EN
    exp_q.push_back(SW'(NB));
`endif
    for (int i = 0; i < NB; i++) exp_q.push_back(SW'(i));
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (n_tx < n && k < 300) begin
      tick(1);
      k++;
    end
    chk("tx_count", n_tx, n);
  endtask

  task automatic drain();
    logic [SW-1:0] g;
    logic [31:0] w;
    while (obs_q.size() > 0) begin
      g = obs_q.pop_front();
      w = (exp_q.size() > 0) ? 32'(exp_q.pop_front())
                             : 32'hFFFF_FFFF;
      chk("send_sel", 32'(g), w);
    end
  endtask

  task automatic wait_sum_en();
    for (int k = 0; k < 60 && !bus.sum_en; k++) tick(1);
  endtask

  initial begin
    int c0;
    reset_n       = 1'b0;
    uart_en       = 1'b1;
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.sum_ready = 1'b0;
    tick(3);
    chk("rst_sum_en", bus.sum_en, 0);
    chk("rst_tx_send", bus.tx_send, 0);
    chk("rst_send_sel", bus.send_sel, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_err", bus.err_cmd, 0);
    reset_n = 1'b1;
    tick(2);

    // continuous mode, two frames
    send_cmd(8'h00);
    tick(1);
    chk("cont_mode", bus.mode, 1);
    chk("cont_sum_en", bus.sum_en, 1);
    push_frame();
    bus.sum_ready = 1'b1;
    tick(1);
    bus.sum_ready = 1'b0;
    chk("sum_to_send", bus.tx_send, 1);
    tgt += FL;
    for (int k = 0; k < 50 && !bus.tx_busy; k++) tick(1);
    for (int k = 0; k < 50 && bus.tx_busy; k++) tick(1);
    c0 = cyc;
    for (int k = 0; k < 50 && !bus.tx_send; k++) tick(1);
    chk("gap_latency", cyc - c0, GAP + 1);
    wait_tx(tgt);
    wait_sum_en();
    chk("cont_resume", bus.sum_en, 1);
    chk("cont_mode2", bus.mode, 1);
    drain();
    push_frame();
    pulse_sum();
    tgt += FL;
    wait_tx(tgt);
    wait_sum_en();
    drain();

    // single shot
    send_cmd(8'h02);
    tick(1);
    chk("single_mode", bus.mode, 2);
    push_frame();
    pulse_sum();
    tgt += FL;
    wait_tx(tgt);
    tick(25);
    chk("single_off", bus.mode, 0);
    chk("single_sum_en", bus.sum_en, 0);
    drain();
    pulse_sum();
    tick(5);
    chk("idle_no_send", n_tx, tgt);

    // UART never acknowledges
    uart_en = 1'b0;
    send_cmd(8'h02);
    tick(1);
    push_frame();
    pulse_sum();
    wait_tx(tgt + 1);
    c0 = last_cyc;
    wait_tx(tgt + 2);
    chk("ack_timeout", last_cyc - c0, ACK + GAP + 2);
    tgt += FL;
    wait_tx(tgt);
    tick(25);
    chk("to_mode_off", bus.mode, 0);
    drain();
    uart_en = 1'b1;

    // stop during data byte 1 does not truncate
    send_cmd(8'h00);
    tick(1);
    push_frame();
    pulse_sum();
    wait_tx(tgt + HOFF + 2);
    send_cmd(8'h01);
    tgt += FL;
    wait_tx(tgt);
    tick(25);
    chk("stop_mode", bus.mode, 0);
    chk("stop_sum_en", bus.sum_en, 0);
    chk("stop_no_extra", n_tx, tgt);
    drain();

    // unknown command, then rx/sum race
    send_cmd(8'h00);
    tick(1);
    send_cmd(8'h7E);
    chk("err_pulse", bus.err_cmd, 1);
    tick(1);
    chk("err_clear", bus.err_cmd, 0);
    chk("err_mode", bus.mode, 1);
    chk("err_sum_en", bus.sum_en, 1);
    bus.rx_data   = 8'h02;
    bus.rx_ready  = 1'b1;
    bus.sum_ready = 1'b1;
    tick(1);
    bus.rx_ready  = 1'b0;
    bus.sum_ready = 1'b0;
    chk("race_no_send", bus.tx_send, 0);
    chk("race_decode", bus.sum_en, 0);
    tick(1);
    chk("race_mode", bus.mode, 2);
    chk("race_count", n_tx, tgt);

    // reset inside the gap after the second byte
    push_frame();
    pulse_sum();
    wait_tx(tgt + 2);
    for (int k = 0; k < 50 && !bus.tx_busy; k++) tick(1);
    for (int k = 0; k < 50 && bus.tx_busy; k++) tick(1);
    tick(2);
    chk("pre_rst_mode", bus.mode, 2);
    #4 reset_n = 1'b0;
    #1;
    chk("arst_mode", bus.mode, 0);
    chk("arst_sel", bus.send_sel, 0);
    chk("arst_send", bus.tx_send, 0);
    chk("arst_sum_en", bus.sum_en, 0);
    tgt += 2;
    drain();
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(20);
    chk("post_rst_count", n_tx, tgt);
    chk("post_rst_mode", bus.mode, 0);
    chk("sb_obs_left", obs_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
